// File: rtl/pipelined_adder_tree_if.sv
// Beat input / group result bundle between the CIM readout and the adder tree.
// Latency: none, wires only.
// Backpressure: none; the tree accepts a beat every cycle.
interface pipelined_adder_tree_if #(
   parameter int N_IN  = 16,
   parameter int IN_W  = 1,
   parameter int ACC_W = 16
);
   logic [N_IN*IN_W-1:0] in_data;
   logic                 in_valid;
   logic                 in_first;
   logic                 in_last;
   logic                 acc_mode;
   logic                 out_valid;
   logic [ACC_W-1:0]     out_acc;
   logic                 out_ovf;

   // Producer of beats, consumer of group results.
   modport master (
      output in_data,
      output in_valid,
      output in_first,
      output in_last,
      output acc_mode,
      input  out_valid,
      input  out_acc,
      input  out_ovf
   );

   // The adder tree itself.
   modport slave (
      input  in_data,
      input  in_valid,
      input  in_first,
      input  in_last,
      input  acc_mode,
      output out_valid,
      output out_acc,
      output out_ovf
   );
endinterface

// File: rtl/pipelined_adder_tree.sv
// Pipelined reduction of N_IN unsigned elements per beat, accumulated over multi-beat groups
// (plain add or MSB-first shift-accumulate); ADDER_TREE_SAT_EN selects saturation on overflow.
// Latency: LVL+1 cycles from beat to group result; one beat per cycle, no backpressure.
module pipelined_adder_tree #(
   parameter int N_IN  = 16,
   parameter int IN_W  = 1,
   parameter int ACC_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   pipelined_adder_tree_if.slave tree_if
);

   // Tree depth and the exact width of a full per-beat sum. N_IN is expected to be a
   // power of two and ACC_W >= SUM_W, so a single beat can never overflow the accumulator.
   localparam int LVL   = $clog2(N_IN);
   localparam int SUM_W = IN_W + LVL;
   // Accumulator arithmetic carries two guard bits: one for a plain-add carry and one
   // more for the bit pushed out by the shift in shift-accumulate mode.
   localparam int EXT_W = ACC_W + 2;
   localparam int PAD_W = EXT_W - SUM_W;

   // Beat qualifiers that ride alongside the data through every tree level.
   typedef struct packed {
      logic vld;
      logic first;
      logic last;
      logic mode;
   } side_t;

   genvar j, k;

   // Unpack the flat input bus into elements (level 0 of the tree, not registered).
   logic [IN_W-1:0] in_elem [N_IN];
   generate
      for (k = 0; k < N_IN; k++) begin : g_unpack
         assign in_elem[k] = tree_if.in_data[k*IN_W +: IN_W];
      end
   endgenerate

   // Level j holds N_IN>>j registered sums, each IN_W+j bits wide so no carry is lost.
   generate
      for (j = 1; j <= LVL; j++) begin : g_lvl
         localparam int W = IN_W + j;
         localparam int N = N_IN >> j;

         logic [W-2:0] op_a [N];
         logic [W-2:0] op_b [N];
         logic [W-1:0] sum_q [N];

         // Pick the operand pairs from the level below.
         for (k = 0; k < N; k++) begin : g_ops
            if (j == 1) begin : g_from_in
               assign op_a[k] = in_elem[2*k];
               assign op_b[k] = in_elem[2*k+1];
            end else begin : g_from_lvl
               assign op_a[k] = g_lvl[j-1].sum_q[2*k];
               assign op_b[k] = g_lvl[j-1].sum_q[2*k+1];
            end
         end

         // Register full-width pairwise sums for this level.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int n = 0; n < N; n++) begin
                  sum_q[n] <= '0;
               end
            end else begin
               for (int n = 0; n < N; n++) begin
                  sum_q[n] <= {1'b0, op_a[n]} + {1'b0, op_b[n]};
               end
            end
         end
      end
   endgenerate

   // Sideband pipeline, one entry per tree level. first/last are qualified by valid at
   // entry so later stages never see a stray marker on a bubble.
   side_t side_q [LVL];

   // Shift the beat qualifiers along with the tree data.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < LVL; n++) begin
            side_q[n] <= '0;
         end
      end else begin
         side_q[0] <= '{vld:   tree_if.in_valid,
                        first: tree_if.in_valid & tree_if.in_first,
                        last:  tree_if.in_valid & tree_if.in_last,
                        mode:  tree_if.acc_mode};
         for (int n = 1; n < LVL; n++) begin
            side_q[n] <= side_q[n-1];
         end
      end
   end

   // Output of the last tree level.
   logic [SUM_W-1:0] top_sum;
   side_t            top_side;
   assign top_sum  = g_lvl[LVL].sum_q[0];
   assign top_side = side_q[LVL-1];

   // Accumulator stage state and its next-state values.
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic             mode_q, mode_d;
   logic             out_vld_q, out_vld_d;
   logic [ACC_W-1:0] out_acc_q, out_acc_d;
   logic             out_ovf_q, out_ovf_d;

   logic [EXT_W-1:0] sum_ext;
   logic [EXT_W-1:0] acc_ext;
   logic [EXT_W-1:0] exact;

   assign sum_ext = {{PAD_W{1'b0}}, top_sum};
   assign acc_ext = {2'b00, acc_q};

   // Fold the current beat into the group: load on first, otherwise add or shift-add;
   // overflow is judged on the exact result and stays set until the next first beat.
   always_comb begin
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      mode_d    = mode_q;
      out_vld_d = 1'b0;
      out_acc_d = out_acc_q;
      out_ovf_d = out_ovf_q;
      exact     = '0;
      if (top_side.vld) begin
         if (top_side.first) begin
            exact  = sum_ext;
            ovf_d  = 1'b0;
            mode_d = top_side.mode;
         end else begin
            if (mode_q) begin
               exact = (acc_ext << 1) + sum_ext;
            end else begin
               exact = acc_ext + sum_ext;
            end
            ovf_d = ovf_q | (|exact[EXT_W-1:ACC_W]);
         end
`ifdef ADDER_TREE_SAT_EN
         // Once overflowed the group is pinned at full scale; a shift of full scale
         // always overflows again, so mode 1 stays saturated too.
         acc_d = ovf_d ? {ACC_W{1'b1}} : exact[ACC_W-1:0];
`else
         acc_d = exact[ACC_W-1:0];
`endif
         if (top_side.last) begin
            out_vld_d = 1'b1;
            out_acc_d = acc_d;
            out_ovf_d = ovf_d;
         end
      end
   end

   // Register accumulator state and the held group result.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         mode_q    <= 1'b0;
         out_vld_q <= 1'b0;
         out_acc_q <= '0;
         out_ovf_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         ovf_q     <= ovf_d;
         mode_q    <= mode_d;
         out_vld_q <= out_vld_d;
         out_acc_q <= out_acc_d;
         out_ovf_q <= out_ovf_d;
      end
   end

   assign tree_if.out_valid = out_vld_q;
   assign tree_if.out_acc   = out_acc_q;
   assign tree_if.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Bench for pipelined_adder_tree: three instances (16x1b/16-bit acc, 16x1b/5-bit acc,
// 8x4b/16-bit acc) share one directed stimulus stream and are checked every cycle
// against a beat-level reference model; literal expectations pin the model.
module tb_pipelined_adder_tree;

   localparam int LV [3] = '{4, 4, 3};
   localparam int AW [3] = '{16, 5, 16};
`ifdef ADDER_TREE_SAT_EN
   localparam longint B_OVF4  = 31;
   localparam longint B_SHIFT = 31;
`else
   localparam longint B_OVF4  = 0;
   localparam longint B_SHIFT = 1;
`endif

   logic        clk;
   logic        rst;
   logic [31:0] s_data;
   logic        s_vld, s_first, s_last, s_mode;
   bit          cmp_en;
   int          n_tests;
   int          n_fail;

   pipelined_adder_tree_if #(.N_IN(16), .IN_W(1), .ACC_W(16)) ifa ();
   pipelined_adder_tree_if #(.N_IN(16), .IN_W(1), .ACC_W(5))  ifb ();
   pipelined_adder_tree_if #(.N_IN(8),  .IN_W(4), .ACC_W(16)) ifc ();

   pipelined_adder_tree #(.N_IN(16), .IN_W(1), .ACC_W(16)) u_a (.clk(clk), .rst(rst), .tree_if(ifa));
   pipelined_adder_tree #(.N_IN(16), .IN_W(1), .ACC_W(5))  u_b (.clk(clk), .rst(rst), .tree_if(ifb));
   pipelined_adder_tree #(.N_IN(8),  .IN_W(4), .ACC_W(16)) u_c (.clk(clk), .rst(rst), .tree_if(ifc));

   assign ifa.in_data  = s_data[15:0];
   assign ifa.in_valid = s_vld;
   assign ifa.in_first = s_first;
   assign ifa.in_last  = s_last;
   assign ifa.acc_mode = s_mode;
   assign ifb.in_data  = s_data[15:0];
   assign ifb.in_valid = s_vld;
   assign ifb.in_first = s_first;
   assign ifb.in_last  = s_last;
   assign ifb.acc_mode = s_mode;
   assign ifc.in_data  = s_data;
   assign ifc.in_valid = s_vld;
   assign ifc.in_first = s_first;
   assign ifc.in_last  = s_last;
   assign ifc.acc_mode = s_mode;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int nib_sum(input logic [31:0] v);
      int s = 0;
      for (int i = 0; i < 8; i++) s += int'(v[i*4 +: 4]);
      return s;
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      int sum;
      bit vld;
      bit first;
      bit last;
      bit mode;
   } beat_t;

   beat_t  line [3][4];
   longint macc [3];
   bit     movf [3];
   bit     mmode [3];
   bit     ev [3];
   longint ea [3];
   bit     eo [3];
   longint pq_a [$];
   longint pq_c [$];
   longint mb_acc;
   bit     mb_ovf;

   // Each beat reaches the accumulator LV edges after it is sampled; groups are
   // evaluated with exact integer arithmetic and reduced to the accumulator width.
   always @(posedge clk) begin : p_model
      beat_t  nb, ob;
      longint ex, mx;
      bit     nov;
      for (int d = 0; d < 3; d++) begin
         if (rst) begin
            for (int i = 0; i < 4; i++) line[d][i] = '{0, 1'b0, 1'b0, 1'b0, 1'b0};
            macc[d] = 0; movf[d] = 0; mmode[d] = 0;
            ev[d] = 0; ea[d] = 0; eo[d] = 0;
         end else begin
            nb.sum   = (d == 2) ? nib_sum(s_data) : $countones(s_data[15:0]);
            nb.vld   = s_vld;
            nb.first = s_first;
            nb.last  = s_last;
            nb.mode  = s_mode;
            ob = line[d][LV[d]-1];
            for (int i = LV[d] - 1; i > 0; i--) line[d][i] = line[d][i-1];
            line[d][0] = nb;
            ev[d] = 0;
            if (ob.vld) begin
               mx = (longint'(1) << AW[d]) - 1;
               if (ob.first) begin
                  ex = ob.sum; nov = 0; mmode[d] = ob.mode;
               end else begin
                  ex  = mmode[d] ? (macc[d] * 2 + ob.sum) : (macc[d] + ob.sum);
                  nov = movf[d] || (ex > mx);
               end
`ifdef ADDER_TREE_SAT_EN
               macc[d] = nov ? mx : (ex % (mx + 1));
`else
               macc[d] = ex % (mx + 1);
`endif
               movf[d] = nov;
               if (ob.last) begin
                  ev[d] = 1; ea[d] = macc[d]; eo[d] = movf[d];
                  if (d == 0) pq_a.push_back(macc[d]);
                  if (d == 1) begin mb_acc = macc[d]; mb_ovf = movf[d]; end
                  if (d == 2) pq_c.push_back(macc[d]);
               end
            end
         end
      end
   end

   // ---------------- every-cycle compare ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         check("cmp_a_valid", ifa.out_valid, ev[0]);
         check("cmp_a_acc",   ifa.out_acc,   ea[0]);
         check("cmp_a_ovf",   ifa.out_ovf,   eo[0]);
         check("cmp_b_valid", ifb.out_valid, ev[1]);
         check("cmp_b_acc",   ifb.out_acc,   ea[1]);
         check("cmp_b_ovf",   ifb.out_ovf,   eo[1]);
         check("cmp_c_valid", ifc.out_valid, ev[2]);
         check("cmp_c_acc",   ifc.out_acc,   ea[2]);
         check("cmp_c_ovf",   ifc.out_ovf,   eo[2]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic beat(input logic [31:0] d, input bit v, input bit f, input bit l, input bit m);
      s_data = d; s_vld = v; s_first = f; s_last = l; s_mode = m;
      @(negedge clk);
   endtask

   // Bubbles carry junk data and markers that must be ignored.
   task automatic idle(input int n);
      repeat (n) beat($urandom, 1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
   endtask

   task automatic pin_a(input string nm, input longint exp);
      if (pq_a.size() == 0) check(nm, -1, exp);
      else check(nm, pq_a.pop_front(), exp);
   endtask

   task automatic pin_c(input string nm, input longint exp);
      if (pq_c.size() == 0) check(nm, -1, exp);
      else check(nm, pq_c.pop_front(), exp);
   endtask

   initial begin
      n_tests = 0; n_fail = 0; cmp_en = 0;
      rst = 1'b1; s_data = '0; s_vld = 0; s_first = 0; s_last = 0; s_mode = 0;
      @(negedge clk);
      cmp_en = 1;
      check("reset_valid_a", ifa.out_valid, 0);
      check("reset_acc_a",   ifa.out_acc,   0);
      check("reset_ovf_b",   ifb.out_ovf,   0);
      check("reset_acc_c",   ifc.out_acc,   0);
      @(negedge clk);
      rst = 1'b0;

      // Single-beat popcount and latency: A shows the result 5 cycles on, C 4 cycles on.
      beat(32'hFFFF_FFFF, 1, 1, 1, 0);
      idle(2);
      check("lat_a_early", ifa.out_valid, 0);
      idle(1);
      check("lat_c_valid", ifc.out_valid, 1);
      check("width_c_acc", ifc.out_acc, 120);
      check("lat_a_early2", ifa.out_valid, 0);
      idle(1);
      check("pop_ffff_valid", ifa.out_valid, 1);
      check("pop_ffff_acc",   ifa.out_acc, 16);
      check("pop_ffff_ovf",   ifa.out_ovf, 0);
      idle(3);
      check("pop_ffff_held", ifa.out_acc, 16);
      pin_a("model_pop_ffff", 16);
      pin_c("model_width_c", 120);

      // Back-to-back single-beat groups.
      beat(32'h0000_0000, 1, 1, 1, 0);
      beat(32'h1234_A5A5, 1, 1, 1, 0);
      idle(6);
      pin_a("model_pop_0000", 0);
      pin_a("model_pop_a5a5", 8);
      pin_c("model_c_zero", 0);
      pin_c("model_c_1234a5a5", 40);

      // Plain accumulate with an in-group bubble, then an immediate next group.
      beat(32'h0000_000F, 1, 1, 0, 0);
      idle(1);
      beat(32'h0000_00FF, 1, 0, 0, 0);
      beat(32'h0000_FFFF, 1, 0, 1, 0);
      beat(32'h0000_0003, 1, 1, 0, 0);
      beat(32'h0000_0001, 1, 0, 1, 0);
      idle(6);
      pin_a("model_plain_28", 28);
      pin_a("model_plain_next", 3);
      pin_c("model_c_plain", 105);
      pin_c("model_c_plain_next", 4);

      // Shift-accumulate, with acc_mode dropped mid-group.
      beat(32'h0000_0007, 1, 1, 0, 1);
      beat(32'h0000_0000, 1, 0, 0, 0);
      beat(32'h0000_001F, 1, 0, 1, 0);
      idle(6);
      check("shift_acc_a", ifa.out_acc, 17);
      pin_a("model_shift_17", 17);
      pin_c("model_c_shift", 44);

      // Four full beats: B (5-bit) overflows; acc_mode raised mid-group is ignored.
      beat(32'h0000_FFFF, 1, 1, 0, 0);
      beat(32'h0000_FFFF, 1, 0, 0, 1);
      beat(32'h0000_FFFF, 1, 0, 0, 0);
      beat(32'h0000_FFFF, 1, 0, 1, 0);
      idle(6);
      check("ovf4_acc_b", ifb.out_acc, B_OVF4);
      check("ovf4_ovf_b", ifb.out_ovf, 1);
      check("model_ovf4_b", mb_acc, B_OVF4);
      pin_a("model_ovf4_a", 64);
      pin_c("model_ovf4_c", 240);

      // Overflow produced by the shift itself in mode 1.
      beat(32'h0000_FFFF, 1, 1, 0, 1);
      beat(32'h0000_0001, 1, 0, 1, 0);
      idle(6);
      check("shift_ovf_acc_b", ifb.out_acc, B_SHIFT);
      check("shift_ovf_ovf_b", ifb.out_ovf, 1);
      check("model_shift_ovf_b", mb_ovf, 1);
      pin_a("model_shift_ovf_a", 33);
      pin_c("model_shift_ovf_c", 121);

      // Reset two cycles after a last beat kills the result and clears outputs.
      beat(32'h0000_00FF, 1, 1, 1, 0);
      idle(1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("rst_acc_a",   ifa.out_acc,   0);
      check("rst_valid_a", ifa.out_valid, 0);
      check("rst_acc_b",   ifb.out_acc,   0);
      check("rst_ovf_b",   ifb.out_ovf,   0);
      check("rst_acc_c",   ifc.out_acc,   0);
      idle(6);
      check("rst_no_pulse_a", pq_a.size(), 0);
      check("rst_no_pulse_c", pq_c.size(), 0);

      // first re-issued mid-group: only the new group is reported.
      beat(32'h0000_00FF, 1, 1, 0, 0);
      beat(32'h0000_0F0F, 1, 0, 0, 0);
      beat(32'h0000_0001, 1, 1, 0, 0);
      beat(32'h0000_0003, 1, 0, 1, 0);
      idle(6);
      pin_a("model_restart_a", 3);
      pin_c("model_restart_c", 4);
      check("restart_one_pulse", pq_a.size(), 0);

      // Beats with no open group keep accumulating onto the previous total.
      beat(32'h0000_000F, 1, 0, 0, 0);
      beat(32'h0000_0001, 1, 0, 1, 1);
      idle(6);
      check("noopen_acc_a", ifa.out_acc, 8);
      pin_a("model_noopen_a", 8);
      pin_c("model_noopen_c", 20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
